// File: rtl/alu_pipe_if.sv
// Operand/result bundle between the register-file read port and write-back.
// The ALU is the slave; whoever issues operations is the master.
interface alu_pipe_if #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic [SHW-1:0]   shamt;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic [3:0]       flags;

   modport master (
      output in_valid, a, b, op, shamt,
      input  in_ready, out_valid, out, out_hi, flags
   );

   modport slave (
      input  in_valid, a, b, op, shamt,
      output in_ready, out_valid, out, out_hi, flags
   );
endinterface

// File: rtl/alu_pipe.sv
// WIDTH-bit ALU: single-cycle ops with latency 1, plus an iterative shift-and-add
// multiplier that holds off the input side for WIDTH cycles.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_ADC = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_SBC = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_ORR = 4'h5;
   localparam logic [3:0] OP_EOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_LSL = 4'h8;
   localparam logic [3:0] OP_LSR = 4'h9;
   localparam logic [3:0] OP_ASR = 4'hA;
   localparam logic [3:0] OP_ROR = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             state, state_nxt;
   logic               ready;
   logic               accept;
   logic               mul_last;
   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   mcand, mplier, acc_hi;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   prod_hi, prod_lo;

   logic [WIDTH-1:0]   out_q, out_hi_q;
   logic [3:0]         flags_q;
   logic               out_valid_q;

   // Single-cycle datapath
   logic               is_sub, cin;
   logic [WIDTH-1:0]   b_op;
   logic [WIDTH:0]     sum;
   logic               add_v;
   logic [WIDTH:0]     lsl_w, lsr_w, asr_w;
   logic [2*WIDTH-1:0] ror_w;
   logic [WIDTH-1:0]   res;
   logic               res_c, res_v;
   logic [3:0]         res_flags;

   assign accept   = bus.in_valid & (state == S_IDLE);
   assign mul_last = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (bus.in_valid && bus.op == OP_MUL) state_nxt = S_MUL;
         end
         S_MUL: begin
            if (mul_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // flags_q already holds the previous op's C in the cycle its out_valid is
   // high, so a back-to-back ADC/SBC sees the freshly written carry.
   always_comb begin
      is_sub = (bus.op == OP_SUB) || (bus.op == OP_SBC);
      b_op   = is_sub ? ~bus.b : bus.b;
      case (bus.op)
         OP_ADC, OP_SBC: cin = flags_q[1];
         OP_SUB:         cin = 1'b1;
         default:        cin = 1'b0;
      endcase
      sum   = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
      add_v = (bus.a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);

      // The extra bit below/above the operand catches the last bit shifted out.
      lsl_w = {1'b0, bus.a} << bus.shamt;
      lsr_w = {bus.a, 1'b0} >> bus.shamt;
      asr_w = $signed({bus.a, 1'b0}) >>> bus.shamt;
      ror_w = {bus.a, bus.a} >> bus.shamt;

      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (bus.op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = add_v;
         end
         OP_AND: res = bus.a & bus.b;
         OP_ORR: res = bus.a | bus.b;
         OP_EOR: res = bus.a ^ bus.b;
         OP_NOT: res = ~bus.b;
         OP_LSL: begin
            res   = lsl_w[WIDTH-1:0];
            res_c = lsl_w[WIDTH];
         end
         OP_LSR: begin
            res   = lsr_w[WIDTH:1];
            res_c = lsr_w[0];
         end
         OP_ASR: begin
            res   = asr_w[WIDTH:1];
            res_c = asr_w[0];
         end
         OP_ROR: begin
            res   = ror_w[WIDTH-1:0];
            res_c = lsr_w[0];
         end
         default: ;
      endcase
      res_flags = {res[WIDTH-1], (res == '0), res_c, res_v};
   end

   // One multiplier step: add the multiplicand when the current multiplier bit
   // is set, then shift the {acc_hi, mplier} pair right by one.
   always_comb begin
      mul_sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      prod_hi = mul_sum[WIDTH:1];
      prod_lo = {mul_sum[0], mplier[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         out_hi_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         cnt         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         acc_hi      <= '0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept) begin
            if (bus.op == OP_MUL) begin
               mcand  <= bus.a;
               mplier <= bus.b;
               acc_hi <= '0;
               cnt    <= '0;
            end else begin
               out_q       <= res;
               out_hi_q    <= '0;
               flags_q     <= res_flags;
               out_valid_q <= 1'b1;
            end
         end
         if (state == S_MUL) begin
            acc_hi <= prod_hi;
            mplier <= prod_lo;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               out_q       <= prod_lo;
               out_hi_q    <= prod_hi;
               flags_q     <= {prod_hi[WIDTH-1], ({prod_hi, prod_lo} == '0), (prod_hi != '0), 1'b0};
               out_valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.out_hi    = out_hi_q;
   assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Random and directed stimulus for alu_pipe, checked cycle by cycle against a
// plain-arithmetic model of the ALU and the multiplier timing.
module tb_alu_pipe;
   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(W)) bus ();
   alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int checks = 0;
   int errors = 0;

   // Model state
   logic [W-1:0] m_out, m_hi;
   logic [3:0]   m_fl;
   logic         m_valid;
   int           m_cnt;
   int           m_ma, m_mb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
   endfunction

   task automatic ref_op(input int op, input int a, input int b, input int sh, input int cin,
                         output logic [W-1:0] r, output logic [3:0] fl);
      int t, c, v, sr;
      t = 0; c = 0; v = 0;
      case (op)
         0, 1: begin
            if (op == 0) cin = 0;
            t  = a + b + cin;
            c  = (t > MASK);
            sr = sgn(a) + sgn(b) + cin;
            v  = (sr > MASK / 2) || (sr < -(MASK / 2) - 1);
         end
         2, 3: begin
            if (op == 2) cin = 1;
            t  = a + (MASK - b) + cin;
            c  = (t > MASK);
            sr = sgn(a) - sgn(b) - 1 + cin;
            v  = (sr > MASK / 2) || (sr < -(MASK / 2) - 1);
         end
         4:  t = a & b;
         5:  t = a | b;
         6:  t = a ^ b;
         7:  t = ~b;
         8: begin t = a << sh; c = (sh != 0) ? (a >> (W - sh)) & 1 : 0; end
         9: begin t = a >> sh; c = (sh != 0) ? (a >> (sh - 1)) & 1 : 0; end
         10: begin t = sgn(a) >>> sh; c = (sh != 0) ? (a >> (sh - 1)) & 1 : 0; end
         11: begin t = (a >> sh) | (a << (W - sh)); c = (sh != 0) ? (a >> (sh - 1)) & 1 : 0; end
         default: t = 0;
      endcase
      t  = t & MASK;
      r  = W'(t);
      fl = {r[W-1], (t == 0), c[0], v[0]};
   endtask

   // Advance one clock with whatever inputs are currently driven, then compare.
   task automatic step();
      int p;
      if (rst) begin
         m_out = '0; m_hi = '0; m_fl = '0; m_valid = 1'b0; m_cnt = 0;
      end else begin
         m_valid = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               p       = m_ma * m_mb;
               m_out   = W'(p & MASK);
               m_hi    = W'(p >> W);
               m_fl    = {m_hi[W-1], (p == 0), (m_hi != 0), 1'b0};
               m_valid = 1'b1;
            end
         end else if (bus.in_valid) begin
            if (bus.op == 4'hC) begin
               m_ma  = int'(bus.a);
               m_mb  = int'(bus.b);
               m_cnt = W;
            end else begin
               ref_op(int'(bus.op), int'(bus.a), int'(bus.b), int'(bus.shamt), int'(m_fl[1]), m_out, m_fl);
               m_hi    = '0;
               m_valid = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(m_cnt == 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out", 32'(bus.out), 32'(m_out));
      chk("out_hi", 32'(bus.out_hi), 32'(m_hi));
      chk("flags", 32'(bus.flags), 32'(m_fl));
   endtask

   task automatic drive(input int op, input int a, input int b, input int sh);
      bus.in_valid = 1'b1;
      bus.op       = 4'(op);
      bus.a        = W'(a);
      bus.b        = W'(b);
      bus.shamt    = 3'(sh);
   endtask

   task automatic do_op(input int op, input int a, input int b, input int sh);
      drive(op, a, b, sh);
      step();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      step();
   endtask

   initial begin
      int k;
      bus.in_valid = 1'b0;
      bus.a = '0; bus.b = '0; bus.op = '0; bus.shamt = '0;
      rst = 1'b1;
      step();
      step();
      chk("rst_out", 32'(bus.out), 32'h0);
      chk("rst_flags", 32'(bus.flags), 32'h0);
      chk("rst_ready", 32'(bus.in_ready), 32'h1);
      rst = 1'b0;
      idle();

      do_op(0, 'h7F, 'h01, 0);
      chk("add_out", 32'(bus.out), 32'h80);
      chk("add_fl", 32'(bus.flags), 32'h9);
      do_op(2, 'h10, 'h20, 0);
      chk("sub_out", 32'(bus.out), 32'hF0);
      chk("sub_fl", 32'(bus.flags), 32'h8);
      do_op(2, 'h20, 'h20, 0);
      chk("sub0_fl", 32'(bus.flags), 32'h6);
      do_op(0, 'hFF, 'h01, 0);
      chk("addc_fl", 32'(bus.flags), 32'h6);
      do_op(1, 'h00, 'h00, 0);
      chk("adc_out", 32'(bus.out), 32'h01);
      chk("adc_fl", 32'(bus.flags), 32'h0);
      do_op(8, 'h81, 0, 1);
      chk("lsl_out", 32'(bus.out), 32'h02);
      chk("lsl_fl", 32'(bus.flags), 32'h2);
      do_op(10, 'h80, 0, 3);
      chk("asr_out", 32'(bus.out), 32'hF0);
      chk("asr_fl", 32'(bus.flags), 32'h8);
      do_op(11, 'h01, 0, 1);
      chk("ror_out", 32'(bus.out), 32'h80);
      chk("ror_fl", 32'(bus.flags), 32'hA);
      do_op(13, 'h55, 'h33, 2);
      chk("rsv_fl", 32'(bus.flags), 32'h4);
      idle();

      // MUL FF*FF with in_valid held high (and ignored) while busy
      do_op(12, 'hFF, 'hFF, 0);
      drive(0, 'h11, 'h22, 0);
      k = 1;
      step();
      while (!bus.out_valid && k < 20) begin
         k++;
         step();
      end
      chk("mul_lat", 32'(k), 32'd8);
      chk("mul_hi", 32'(bus.out_hi), 32'hFE);
      chk("mul_lo", 32'(bus.out), 32'h01);
      chk("mul_fl", 32'(bus.flags), 32'hA);
      idle();

      // Reset part-way through a multiply
      rst = 1'b1; step(); rst = 1'b0;
      do_op(12, 'h03, 'h05, 0);
      bus.in_valid = 1'b0;
      step(); step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("mulrst_ready", 32'(bus.in_ready), 32'h1);
      chk("mulrst_valid", 32'(bus.out_valid), 32'h0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("mulrst_noout", 32'(bus.out_valid), 32'h0);
      end
      chk("mulrst_out", 32'(bus.out), 32'h0);
      chk("mulrst_fl", 32'(bus.flags), 32'h0);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid = ($urandom_range(0, 9) < 7);
         bus.op       = ($urandom_range(0, 9) == 0) ? 4'hC : 4'($urandom_range(0, 15));
         bus.a        = W'($urandom);
         bus.b        = W'($urandom);
         bus.shamt    = 3'($urandom);
         rst          = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
